fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 39 +++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, canonical NOP and the IF/ID entry layout.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  // Empty IF/ID slot, used both for reset and for flushes.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc    = '0;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority per edge: rst > flush > hold > load.
module if_id_reg
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  logic   hold,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t entry_q, entry_d;

  // Select the next IF/ID contents from the control inputs.
  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d = if_id_bubble();
    end else if (hold) begin
      entry_d = entry_q;
    end else if (load) begin
      entry_d = d;
    end
  end

  // Register with synchronous reset to an invalid NOP slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= if_id_bubble();
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC mux and the IF/ID register.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to add the instr_misalign pulse output.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        instr_misalign,
`endif
  output logic        if_id_valid
);

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          fetch_entry;
  if_id_t          if_id_q;

  // Next-PC mux: redirect beats stall beats sequential advance (wraps modulo 2^32).
  always_comb begin
    pc_d = pc_q;
    if (br_taken) begin
      pc_d = {br_target[31:2], 2'b00};
    end else if (!stall_if) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = pc_q;

  assign fetch_entry.pc    = pc_q;
  assign fetch_entry.instr = imem_rdata;
  assign fetch_entry.valid = 1'b1;

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (!stall_if && !br_taken),
    .flush (br_taken),
    .hold  (stall_if && !br_taken),
    .d     (fetch_entry),
    .q     (if_id_q)
  );

  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  // One-cycle flag for a redirect whose target was not word aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= br_taken && (br_target[1:0] != 2'b00);
    end
  end

  assign instr_misalign = misalign_q;
`else
  // Low target bits are simply dropped when the check is not built.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^br_target[1:0];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall_if, br_taken;
  logic [31:0] br_target, imem_addr, imem_rdata, if_id_pc, if_id_instr;
  logic        if_id_valid;

  logic        rst2;
  logic [31:0] imem_addr2, imem_rdata2, if_id_pc2, if_id_instr2;
  logic        if_id_valid2;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic instr_misalign, instr_misalign2;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1234_0013;
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall_if    (stall_if),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
`ifdef FETCH_MISALIGN_CHECK_EN
    .instr_misalign (instr_misalign),
`endif
    .if_id_valid (if_id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk         (clk),
    .rst         (rst2),
    .stall_if    (1'b0),
    .br_taken    (1'b0),
    .br_target   (32'h0),
    .imem_addr   (imem_addr2),
    .imem_rdata  (imem_rdata2),
    .if_id_pc    (if_id_pc2),
    .if_id_instr (if_id_instr2),
`ifdef FETCH_MISALIGN_CHECK_EN
    .instr_misalign (instr_misalign2),
`endif
    .if_id_valid (if_id_valid2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_if = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    step();
    step();
    total_cnt++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_id_valid); else pass_cnt++;
    total_cnt++; if (if_id_instr !== NOP) $display("FAIL reset_instr: got %h want %h", if_id_instr, NOP); else pass_cnt++;
    total_cnt++; if (if_id_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", if_id_pc); else pass_cnt++;
`ifdef FETCH_MISALIGN_CHECK_EN
    total_cnt++; if (instr_misalign !== 1'b0) $display("FAIL reset_mis: got %b want 0", instr_misalign); else pass_cnt++;
`endif
  endtask

  task automatic test_free_run();
    rst = 1'b0;
    #1;
    total_cnt++; if (imem_addr !== 32'h0) $display("FAIL run_addr0: got %h want 0", imem_addr); else pass_cnt++;
    step();
    total_cnt++; if (imem_addr !== 32'h4) $display("FAIL run_addr1: got %h want 4", imem_addr); else pass_cnt++;
    total_cnt++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1) $display("FAIL run_ifid0: got pc %h v %b want 0/1", if_id_pc, if_id_valid); else pass_cnt++;
    total_cnt++; if (if_id_instr !== mem_word(32'h0)) $display("FAIL run_instr0: got %h want %h", if_id_instr, mem_word(32'h0)); else pass_cnt++;
    step();
    total_cnt++; if (imem_addr !== 32'h8) $display("FAIL run_addr2: got %h want 8", imem_addr); else pass_cnt++;
    total_cnt++; if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1) $display("FAIL run_ifid1: got pc %h v %b want 4/1", if_id_pc, if_id_valid); else pass_cnt++;
  endtask

  task automatic test_stall();
    stall_if = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++; if (imem_addr !== 32'h8) $display("FAIL stall_addr%0d: got %h want 8", i, imem_addr); else pass_cnt++;
      total_cnt++; if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h4))
        $display("FAIL stall_ifid%0d: got pc %h v %b i %h want 4/1/%h", i, if_id_pc, if_id_valid, if_id_instr, mem_word(32'h4));
      else pass_cnt++;
    end
    stall_if = 1'b0;
    step();
    total_cnt++; if (imem_addr !== 32'hC) $display("FAIL stall_resume_addr: got %h want c", imem_addr); else pass_cnt++;
    total_cnt++; if (if_id_pc !== 32'h8 || if_id_instr !== mem_word(32'h8)) $display("FAIL stall_resume_ifid: got pc %h i %h want 8/%h", if_id_pc, if_id_instr, mem_word(32'h8)); else pass_cnt++;
  endtask

  task automatic test_branch();
    br_taken = 1'b1; br_target = 32'h100;
    step();
    br_taken = 1'b0;
    total_cnt++; if (imem_addr !== 32'h100) $display("FAIL br_addr: got %h want 100", imem_addr); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0)
      $display("FAIL br_flush: got pc %h i %h v %b want 0/%h/0", if_id_pc, if_id_instr, if_id_valid, NOP);
    else pass_cnt++;
    step();
    total_cnt++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h100))
      $display("FAIL br_first: got pc %h v %b i %h want 100/1/%h", if_id_pc, if_id_valid, if_id_instr, mem_word(32'h100));
    else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h104) $display("FAIL br_next_addr: got %h want 104", imem_addr); else pass_cnt++;
  endtask

  task automatic test_branch_stall();
    br_taken = 1'b1; stall_if = 1'b1; br_target = 32'h40;
    step();
    br_taken = 1'b0; stall_if = 1'b0;
    total_cnt++; if (imem_addr !== 32'h40) $display("FAIL brst_addr: got %h want 40", imem_addr); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) $display("FAIL brst_flush: got v %b i %h want 0/%h", if_id_valid, if_id_instr, NOP); else pass_cnt++;
    step();
    total_cnt++; if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1) $display("FAIL brst_first: got pc %h v %b want 40/1", if_id_pc, if_id_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    br_taken = 1'b1; br_target = 32'h80;
    step();
    total_cnt++; if (imem_addr !== 32'h80 || if_id_valid !== 1'b0) $display("FAIL b2b_0: got a %h v %b want 80/0", imem_addr, if_id_valid); else pass_cnt++;
    br_target = 32'h90;
    step();
    br_taken = 1'b0;
    total_cnt++; if (imem_addr !== 32'h90 || if_id_valid !== 1'b0) $display("FAIL b2b_1: got a %h v %b want 90/0", imem_addr, if_id_valid); else pass_cnt++;
    step();
    total_cnt++; if (if_id_pc !== 32'h90 || if_id_valid !== 1'b1) $display("FAIL b2b_first: got pc %h v %b want 90/1", if_id_pc, if_id_valid); else pass_cnt++;
  endtask

  task automatic test_reset_discard();
    rst = 1'b1; stall_if = 1'b1;
    step();
    total_cnt++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0)
      $display("FAIL rst_stall: got a %h pc %h v %b want 0/0/0", imem_addr, if_id_pc, if_id_valid);
    else pass_cnt++;
    stall_if = 1'b0; br_taken = 1'b1; br_target = 32'h200;
    step();
    total_cnt++; if (imem_addr !== 32'h0 || if_id_instr !== NOP) $display("FAIL rst_br: got a %h i %h want 0/%h", imem_addr, if_id_instr, NOP); else pass_cnt++;
    rst = 1'b0; br_taken = 1'b0;
    step();
    total_cnt++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL rst_release: got pc %h v %b a %h want 0/1/4", if_id_pc, if_id_valid, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    #1;
    total_cnt++; if (imem_addr2 !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr2); else pass_cnt++;
    step();
    total_cnt++; if (imem_addr2 !== 32'h0) $display("FAIL wrap_addr1: got %h want 0", imem_addr2); else pass_cnt++;
    total_cnt++; if (if_id_pc2 !== 32'hFFFF_FFFC || if_id_valid2 !== 1'b1) $display("FAIL wrap_ifid: got pc %h v %b want fffffffc/1", if_id_pc2, if_id_valid2); else pass_cnt++;
    step();
    total_cnt++; if (imem_addr2 !== 32'h4 || if_id_pc2 !== 32'h0) $display("FAIL wrap_next: got a %h pc %h want 4/0", imem_addr2, if_id_pc2); else pass_cnt++;
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    br_taken = 1'b1; br_target = 32'h102;
    step();
    br_taken = 1'b0;
    total_cnt++; if (imem_addr !== 32'h100) $display("FAIL mis_addr: got %h want 100", imem_addr); else pass_cnt++;
    total_cnt++; if (instr_misalign !== 1'b1) $display("FAIL mis_pulse: got %b want 1", instr_misalign); else pass_cnt++;
    step();
    total_cnt++; if (instr_misalign !== 1'b0) $display("FAIL mis_clear: got %b want 0", instr_misalign); else pass_cnt++;
    total_cnt++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1) $display("FAIL mis_ifid: got pc %h v %b want 100/1", if_id_pc, if_id_valid); else pass_cnt++;
  endtask
`endif

  // Randomized run against a behavioural model of the fetch rules.
  task automatic test_random();
    logic [31:0] m_pc, m_ifpc, m_ifinstr, t;
    logic        m_ifvalid, m_mis;
    rst = 1'b1; stall_if = 1'b0; br_taken = 1'b0;
    step();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = NOP; m_ifvalid = 1'b0; m_mis = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rst      = ($urandom % 40) == 0;
      stall_if = ($urandom % 4) == 0;
      br_taken = ($urandom % 6) == 0;
      t = $urandom & 32'h0000_0FFF;
      if ($urandom % 2 == 0) t[1:0] = 2'b00;
      br_target = t;
      #1;
      total_cnt++; if (imem_addr !== m_pc) $display("FAIL rnd_addr_comb[%0d]: got %h want %h", i, imem_addr, m_pc); else pass_cnt++;
      if (rst) begin
        m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = NOP; m_ifvalid = 1'b0; m_mis = 1'b0;
      end else begin
        m_mis = br_taken && (t % 4 != 0);
        if (br_taken) begin
          m_pc = t - (t % 4);
          m_ifpc = 32'h0; m_ifinstr = NOP; m_ifvalid = 1'b0;
        end else if (!stall_if) begin
          m_ifpc = m_pc; m_ifinstr = mem_word(m_pc); m_ifvalid = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end
      step();
      total_cnt++; if (imem_addr !== m_pc) $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, m_pc); else pass_cnt++;
      total_cnt++; if (if_id_pc !== m_ifpc || if_id_instr !== m_ifinstr || if_id_valid !== m_ifvalid)
        $display("FAIL rnd_ifid[%0d]: got %h/%h/%b want %h/%h/%b", i, if_id_pc, if_id_instr, if_id_valid, m_ifpc, m_ifinstr, m_ifvalid);
      else pass_cnt++;
`ifdef FETCH_MISALIGN_CHECK_EN
      total_cnt++; if (instr_misalign !== m_mis) $display("FAIL rnd_mis[%0d]: got %b want %b", i, instr_misalign, m_mis); else pass_cnt++;
`endif
    end
    rst = 1'b0; stall_if = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    rst2 = 1'b1;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_back_to_back();
    test_reset_discard();
    test_wrap();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
